id_stage_ctrl: RTL and testbench

Pipeline controller for the ID stage of the RISC-V core. It owns the IF/ID slot register and the valid/ready handshake between IF and EX. It detects load-use hazards and inserts bubbles, and applies branch/jump flushes from EX. It also drives the immediate-select configuration consumed by the ID-stage immediate generator, so the decode datapath is sequenced from one place.

---
 rtl/id_stage_ctrl_pkg.sv | 50 +++++
 rtl/id_stage_ctrl_load_use_detector.sv | 41 ++++
 rtl/id_stage_ctrl.sv | 127 ++++++++++++
 tb/tb_id_stage_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_ctrl_pkg.sv
// Shared core decode types: RV32I opcodes, immediate-format select and ID slot states.
// Also hosts the immediate-format decode so the generator and controller agree.
package id_stage_ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_ITYPE   = 3'd0,
      IMM_LOGICAL = 3'd1,
      IMM_STYPE   = 3'd2,
      IMM_BTYPE   = 3'd3,
      IMM_UTYPE   = 3'd4,
      IMM_JTYPE   = 3'd5
   } imm_sel_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HOLD  = 2'd1,
      ST_STALL = 2'd2
   } id_state_e;

   // Shift-immediates (SLLI/SRLI/SRAI) carry a shamt, not a sign-extended immediate.
   function automatic imm_sel_e imm_sel_decode(input logic [6:0] opcode,
                                               input logic [2:0] funct3);
      imm_sel_e sel;
      sel = IMM_ITYPE;
      case (opcode)
         OPC_OP_IMM: sel = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_LOGICAL : IMM_ITYPE;
         OPC_LOAD,
         OPC_JALR:   sel = IMM_ITYPE;
         OPC_STORE:  sel = IMM_STYPE;
         OPC_BRANCH: sel = IMM_BTYPE;
         OPC_LUI,
         OPC_AUIPC:  sel = IMM_UTYPE;
         OPC_JAL:    sel = IMM_JTYPE;
         default:    sel = IMM_ITYPE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/id_stage_ctrl_load_use_detector.sv
// Combinational load-use check: does the slot instruction read the register
// that the load just issued to EX will write?
module load_use_detector
   import id_stage_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] instr_i,
   input  logic                  ld_pend_i,
   input  logic [4:0]            ld_rd_i,
   output logic                  hazard_o
);

   logic [6:0] opcode;
   logic       rs1_eq;
   logic       rs2_eq;
   logic       match;
   logic       unused_bits;

   assign opcode      = instr_i[6:0];
   assign rs1_eq      = (instr_i[19:15] == ld_rd_i);
   assign rs2_eq      = (instr_i[24:20] == ld_rd_i);
   assign unused_bits = ^{instr_i[DATA_WIDTH-1:25], instr_i[14:7]};

   // Only formats that actually read rs1/rs2 can depend on the load.
   always_comb begin
      match = 1'b0;
      case (opcode)
         OPC_OP,
         OPC_STORE,
         OPC_BRANCH: match = rs1_eq | rs2_eq;
         OPC_OP_IMM,
         OPC_LOAD,
         OPC_JALR:   match = rs1_eq;
         default:    match = 1'b0;
      endcase
   end

   assign hazard_o = ld_pend_i & match;

endmodule

// File: rtl/id_stage_ctrl.sv
// ID-stage pipeline controller: IF/ID slot, IF/EX handshake, load-use bubbles,
// EX flush handling and immediate-format select for the decode datapath.
module id_stage_ctrl
   import id_stage_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  if_valid_i,
   input  logic [DATA_WIDTH-1:0] if_instr_i,
   input  logic [DATA_WIDTH-1:0] if_pc_i,
   output logic                  if_ready_o,
   output logic                  id_valid_o,
   output logic [DATA_WIDTH-1:0] id_instr_o,
   output logic [DATA_WIDTH-1:0] id_pc_o,
   output imm_sel_e              id_imm_sel_o,
   input  logic                  ex_ready_i,
   input  logic                  flush_i,
   output logic [CNT_WIDTH-1:0]  bubble_cnt_o
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic                  ld_pend_q, ld_pend_d;
   logic [4:0]            ld_rd_q, ld_rd_d;
   logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d;

   logic      ld_hazard;
   logic      hazard;
   logic      issue;
   logic      accept;
   logic      slot_is_load;
   id_state_e state;

   load_use_detector #(.DATA_WIDTH(DATA_WIDTH)) u_load_use_detector (
      .instr_i   (instr_q),
      .ld_pend_i (ld_pend_q),
      .ld_rd_i   (ld_rd_q),
      .hazard_o  (ld_hazard)
   );

   assign hazard       = valid_q & ld_hazard;
   assign slot_is_load = (instr_q[6:0] == OPC_LOAD) && (instr_q[11:7] != 5'd0);

   always_comb begin
      state = ST_EMPTY;
      if (valid_q) state = hazard ? ST_STALL : ST_HOLD;
   end

   assign issue      = (state == ST_HOLD) & ex_ready_i;
   assign if_ready_o = ~rst_i & (~valid_q | issue);
   assign accept     = if_valid_i & if_ready_o;

   always_comb begin
      valid_d      = valid_q;
      instr_d      = instr_q;
      pc_d         = pc_q;
      ld_pend_d    = ld_pend_q;
      ld_rd_d      = ld_rd_q;
      bubble_cnt_d = bubble_cnt_q;

      case (state)
         ST_EMPTY: begin
            if (ex_ready_i) ld_pend_d = 1'b0;
            if (accept) begin
               valid_d = 1'b1;
               instr_d = if_instr_i;
               pc_d    = if_pc_i;
            end
         end
         ST_HOLD: begin
            if (issue) begin
               ld_pend_d = slot_is_load;
               ld_rd_d   = instr_q[11:7];
               valid_d   = accept;
               if (accept) begin
                  instr_d = if_instr_i;
                  pc_d    = if_pc_i;
               end
            end
         end
         ST_STALL: begin
            // The bubble drains into EX; the dependent instruction stays put.
            if (ex_ready_i) begin
               ld_pend_d = 1'b0;
               if (!(&bubble_cnt_q))
                  bubble_cnt_d = bubble_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         default: ;
      endcase

      // Redirect wins over everything except reset; the counter is left alone.
      if (flush_i) begin
         valid_d   = 1'b0;
         ld_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q      <= 1'b0;
         instr_q      <= '0;
         pc_q         <= '0;
         ld_pend_q    <= 1'b0;
         ld_rd_q      <= '0;
         bubble_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         pc_q         <= pc_d;
         ld_pend_q    <= ld_pend_d;
         ld_rd_q      <= ld_rd_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign id_valid_o   = (state == ST_HOLD);
   assign id_instr_o   = instr_q;
   assign id_pc_o      = pc_q;
   assign id_imm_sel_o = imm_sel_decode(instr_q[6:0], instr_q[14:12]);
   assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl: streaming, load-use, false-hazard, backpressure,
// flush, mid-stream reset and counter saturation (counter narrowed to keep runtime short).
module tb_id_stage_ctrl;
   import id_stage_ctrl_pkg::*;

   localparam int DW = 32;
   localparam int CW = 6;

   localparam logic [31:0] I_ADDI   = 32'h00500093; // addi x1,x0,5
   localparam logic [31:0] I_SW     = 32'h00112023; // sw x1,0(x2)
   localparam logic [31:0] I_LW5    = 32'h0000A283; // lw x5,0(x1)
   localparam logic [31:0] I_ADD5   = 32'h00728333; // add x6,x5,x7
   localparam logic [31:0] I_SW5    = 32'h00512023; // sw x5,0(x2)
   localparam logic [31:0] I_LW0    = 32'h0000A003; // lw x0,0(x1)
   localparam logic [31:0] I_ADD0   = 32'h00700333; // add x6,x0,x7
   localparam logic [31:0] I_LUI5   = 32'h000012B7; // lui x5,1
   localparam logic [31:0] I_SLLI   = 32'h00109093; // slli x1,x1,1
   localparam logic [31:0] I_JAL    = 32'h0000006F; // jal x0,0
   localparam logic [31:0] I_LW55   = 32'h0002A283; // lw x5,0(x5)

   logic          clk = 1'b0;
   logic          rst;
   logic          if_valid;
   logic [DW-1:0] if_instr;
   logic [DW-1:0] if_pc;
   logic          if_ready;
   logic          id_valid;
   logic [DW-1:0] id_instr;
   logic [DW-1:0] id_pc;
   imm_sel_e      id_imm_sel;
   logic          ex_ready;
   logic          flush;
   logic [CW-1:0] bubble_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_stage_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .if_valid_i   (if_valid),
      .if_instr_i   (if_instr),
      .if_pc_i      (if_pc),
      .if_ready_o   (if_ready),
      .id_valid_o   (id_valid),
      .id_instr_o   (id_instr),
      .id_pc_o      (id_pc),
      .id_imm_sel_o (id_imm_sel),
      .ex_ready_i   (ex_ready),
      .flush_i      (flush),
      .bubble_cnt_o (bubble_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge; outputs are then checked before the next rising edge.
   task automatic drv(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic exr, input logic fl, input logic rs);
      @(negedge clk);
      if_valid = v;
      if_instr = ins;
      if_pc    = pc;
      ex_ready = exr;
      flush    = fl;
      rst      = rs;
      #1;
   endtask

   initial begin
      rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; ex_ready = 1'b0; flush = 1'b0;

      // reset state
      drv(0, 0, 0, 1, 0, 1);
      drv(0, 0, 0, 1, 0, 1);
      chk("rst_id_valid", {31'b0, id_valid}, 0);
      chk("rst_if_ready", {31'b0, if_ready}, 0);
      chk("rst_id_instr", id_instr, 0);
      chk("rst_id_pc", id_pc, 0);
      chk("rst_imm_sel", {29'b0, id_imm_sel}, {29'b0, IMM_ITYPE});
      chk("rst_bubble", {26'b0, bubble_cnt}, 0);

      // streaming: addi then sw back-to-back
      drv(1, I_ADDI, 32'h100, 1, 0, 0);
      chk("s1_if_ready", {31'b0, if_ready}, 1);
      chk("s1_id_valid", {31'b0, id_valid}, 0);
      drv(1, I_SW, 32'h104, 1, 0, 0);
      chk("s2_id_valid", {31'b0, id_valid}, 1);
      chk("s2_id_instr", id_instr, I_ADDI);
      chk("s2_id_pc", id_pc, 32'h100);
      chk("s2_imm_itype", {29'b0, id_imm_sel}, {29'b0, IMM_ITYPE});
      chk("s2_if_ready", {31'b0, if_ready}, 1);
      drv(0, 0, 0, 1, 0, 0);
      chk("s3_id_valid", {31'b0, id_valid}, 1);
      chk("s3_id_instr", id_instr, I_SW);
      chk("s3_imm_stype", {29'b0, id_imm_sel}, {29'b0, IMM_STYPE});
      chk("s3_bubble", {26'b0, bubble_cnt}, 0);

      // load-use: lw x5 then add x6,x5,x7
      drv(1, I_LW5, 32'h108, 1, 0, 0);
      chk("s4_id_valid", {31'b0, id_valid}, 0);
      drv(1, I_ADD5, 32'h10C, 1, 0, 0);
      chk("s5_id_instr", id_instr, I_LW5);
      chk("s5_id_valid", {31'b0, id_valid}, 1);
      drv(1, I_ADDI, 32'h110, 1, 0, 0);
      chk("lu_stall_valid", {31'b0, id_valid}, 0);
      chk("lu_stall_ready", {31'b0, if_ready}, 0);
      chk("lu_stall_instr", id_instr, I_ADD5);
      chk("lu_stall_bubble", {26'b0, bubble_cnt}, 0);
      drv(0, 0, 0, 1, 0, 0);
      chk("lu_issue_valid", {31'b0, id_valid}, 1);
      chk("lu_issue_instr", id_instr, I_ADD5);
      chk("lu_issue_pc", id_pc, 32'h10C);
      chk("lu_bubble_1", {26'b0, bubble_cnt}, 1);
      chk("lu_if_ready", {31'b0, if_ready}, 1);

      // backpressure during stall (rs2 dependency via sw)
      drv(1, I_LW5, 32'h200, 1, 0, 0);
      drv(1, I_SW5, 32'h204, 1, 0, 0);
      chk("bp_lw_valid", {31'b0, id_valid}, 1);
      for (int i = 0; i < 3; i++) begin
         drv(0, 0, 0, 0, 0, 0);
         chk("bp_stall_valid", {31'b0, id_valid}, 0);
         chk("bp_stall_bubble", {26'b0, bubble_cnt}, 1);
      end
      drv(0, 0, 0, 1, 0, 0);
      chk("bp_release_valid", {31'b0, id_valid}, 0);
      chk("bp_release_ready", {31'b0, if_ready}, 0);
      drv(0, 0, 0, 1, 0, 0);
      chk("bp_issue_valid", {31'b0, id_valid}, 1);
      chk("bp_issue_instr", id_instr, I_SW5);
      chk("bp_bubble_2", {26'b0, bubble_cnt}, 2);

      // no false hazard: lw x0 / add x0
      drv(1, I_LW0, 32'h300, 1, 0, 0);
      drv(1, I_ADD0, 32'h304, 1, 0, 0);
      drv(1, I_LW5, 32'h308, 1, 0, 0);
      chk("nf_x0_valid", {31'b0, id_valid}, 1);
      chk("nf_x0_instr", id_instr, I_ADD0);
      // lw x5 then lui x5
      drv(1, I_LUI5, 32'h30C, 1, 0, 0);
      drv(1, I_SLLI, 32'h310, 1, 0, 0);
      chk("nf_lui_valid", {31'b0, id_valid}, 1);
      chk("nf_lui_imm", {29'b0, id_imm_sel}, {29'b0, IMM_UTYPE});
      chk("nf_lui_ready", {31'b0, if_ready}, 1);
      chk("nf_bubble", {26'b0, bubble_cnt}, 2);
      drv(1, I_JAL, 32'h314, 1, 0, 0);
      chk("slli_imm_logical", {29'b0, id_imm_sel}, {29'b0, IMM_LOGICAL});

      // flush with jal in slot while IF presents an instruction
      drv(1, I_ADDI, 32'h400, 1, 1, 0);
      chk("fl_jal_imm", {29'b0, id_imm_sel}, {29'b0, IMM_JTYPE});
      chk("fl_jal_valid", {31'b0, id_valid}, 1);
      drv(0, 0, 0, 1, 0, 0);
      chk("fl_next_valid", {31'b0, id_valid}, 0);
      chk("fl_next_ready", {31'b0, if_ready}, 1);
      // flush in the cycle a load issues: tracker must be cleared
      drv(1, I_LW5, 32'h500, 1, 0, 0);
      chk("fl_after_valid", {31'b0, id_valid}, 0);
      drv(0, 0, 0, 1, 1, 0);
      drv(1, I_ADD5, 32'h504, 1, 0, 0);
      drv(0, 0, 0, 1, 0, 0);
      chk("fl_ldpend_cleared", {31'b0, id_valid}, 1);
      chk("fl_ldpend_bubble", {26'b0, bubble_cnt}, 2);
      // flush during STALL with ex_ready low
      drv(1, I_LW5, 32'h600, 1, 0, 0);
      drv(1, I_ADD5, 32'h604, 1, 0, 0);
      drv(0, 0, 0, 0, 1, 0);
      chk("fl_stall_valid", {31'b0, id_valid}, 0);
      drv(0, 0, 0, 1, 0, 0);
      chk("fl_stall_killed", {31'b0, id_valid}, 0);
      chk("fl_stall_bubble", {26'b0, bubble_cnt}, 2);

      // reset mid-stream
      drv(1, I_ADDI, 32'h700, 1, 0, 0);
      drv(1, I_SW, 32'h704, 1, 0, 1);
      chk("mrst_if_ready", {31'b0, if_ready}, 0);
      drv(0, 0, 0, 1, 0, 1);
      chk("mrst_valid", {31'b0, id_valid}, 0);
      chk("mrst_instr", id_instr, 0);
      chk("mrst_pc", id_pc, 0);
      chk("mrst_imm", {29'b0, id_imm_sel}, {29'b0, IMM_ITYPE});
      chk("mrst_bubble", {26'b0, bubble_cnt}, 0);

      // saturation: self-dependent loads give one bubble every two cycles
      drv(1, I_LW55, 32'h800, 1, 0, 0);
      repeat (10) @(negedge clk);
      #1;
      chk("sat_partial", {26'b0, bubble_cnt}, 4);
      repeat (150) @(negedge clk);
      #1;
      chk("sat_hold", {26'b0, bubble_cnt}, 32'h3F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
